// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost-full/empty levels,
// synchronous flush, sticky overflow/underflow flags and registered read data with a valid strobe.
module sync_fifo_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_empty,
    input  logic [ADDR_W:0]   i_af_level,
    input  logic [ADDR_W:0]   i_ae_level,
    output logic              o_almost_full,
    output logic              o_almost_empty,
    output logic              o_overflow,
    output logic              o_underflow,
    input  logic              i_err_clr
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wrPtr;
    logic [ADDR_W:0]   r_rdPtr;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_rdData;
    logic              r_rdValid;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_rdAccept;
    logic              w_wrAccept;

    assign w_full     = (r_count == FULL_COUNT);
    assign w_empty    = (r_count == '0);
    // A full FIFO can still take a write when a read frees a slot in the same cycle.
    assign w_rdAccept = i_rd_en & ~w_empty;
    assign w_wrAccept = i_wr_en & (~w_full | w_rdAccept);

    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_almost_full  = (r_count >= i_af_level);
    assign o_almost_empty = (r_count <= i_ae_level);
    assign o_count        = r_count;
    assign o_rd_data      = r_rdData;
    assign o_rd_valid     = r_rdValid;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

    always_ff @(posedge clk) begin
        if (w_wrAccept && !i_flush) begin
            r_mem[r_wrPtr[ADDR_W-1:0]] <= i_wr_data;
        end
    end

    // Read of the old slot and write to the same slot coexist: the read sees the pre-write value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
        end else if (i_flush) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_rdValid <= 1'b0;
        end else begin
            r_rdValid <= w_rdAccept;
            if (w_wrAccept) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_rdAccept) begin
                r_rdPtr  <= r_rdPtr + 1'b1;
                r_rdData <= r_mem[r_rdPtr[ADDR_W-1:0]];
            end
            case ({w_wrAccept, w_rdAccept})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (!i_flush) begin
            r_overflow  <= (i_wr_en & ~w_wrAccept) | (r_overflow & ~i_err_clr);
            r_underflow <= (i_rd_en & ~w_rdAccept) | (r_underflow & ~i_err_clr);
        end
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. Generalises the team's fixed 8-bit x 16 FIFO to any data width and power-of-two depth. Adds:
- occupancy count
- programmable almost-full/almost-empty levels
- synchronous flush
- sticky, software-clearable overflow/underflow flags
- registered read data with a valid strobe

Used as the standard buffering element between producer/consumer blocks in the datapath.

Parameters:
DATA_W, 8, data word width in bits (>=1)
ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries (ADDR_W >= 1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of contents/pointers
wr_en  in  1  write request
wr_data  in  DATA_W  write data
rd_en  in  1  read request
rd_data  out  DATA_W  registered read data
rd_valid  out  1  rd_data updated this cycle (one-cycle pulse)
count  out  ADDR_W+1  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
af_level  in  ADDR_W+1  almost-full threshold
ae_level  in  ADDR_W+1  almost-empty threshold
almost_full  out  1  count >= af_level
almost_empty  out  1  count <= ae_level
overflow  out  1  sticky: write dropped
underflow  out  1  sticky: read refused
err_clr  in  1  clears overflow/underflow

Behaviour:
- Reset (rst=0, async) forces:
  - wptr=rptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0
  - full=0, empty=1
  - almost_full/almost_empty follow their combinational definitions from count=0
- Pointers are ADDR_W+1 bits; the MSB is the wrap bit. Memory is indexed by ptr[ADDR_W-1:0]. Pointers wrap modulo 2**(ADDR_W+1).
- full, empty, almost_full and almost_empty are combinational from the registered count and level inputs. Level compares are unsigned, ADDR_W+1 bits wide.
- rd_accept = rd_en & ~empty.
- wr_accept = wr_en & (~full | rd_accept). A write to a full FIFO is accepted if a read is accepted in the same cycle.
- A read of an empty FIFO is never accepted, even with a simultaneous write. There is no fall-through.
- Write: on wr_accept, mem[wptr] <= wr_data and wptr += 1.
- Read: on rd_accept, rd_data <= mem[rptr], rptr += 1, and rd_valid=1 the next cycle.
  - Latency is 1 clock from accepted rd_en to rd_data/rd_valid.
  - rd_data holds its last value when no read is accepted.
  - rd_valid=0 otherwise.
- count update: +1 on wr_accept only; -1 on rd_accept only; unchanged when both or neither.
- Simultaneous read and write at the same address (count==DEPTH with both accepted): the read returns the old entry, then the write overwrites that slot.
- overflow sets on wr_en & ~wr_accept. underflow sets on rd_en & ~rd_accept.
  - Both hold until err_clr=1.
  - If set and err_clr occur in the same cycle, set wins.
- flush=1 (synchronous, priority over rd/wr in that cycle):
  - wptr=rptr=0, count=0, rd_valid=0
  - No write and no read is performed that cycle.
  - rd_data, overflow, underflow and memory contents are unchanged.
- Memory has no reset. Stale contents are never visible, because only accepted reads update rd_data.
- Reset asserted mid-operation: all state above returns to reset values immediately, independent of clk. The first accepted write after deassertion lands at address 0.

Test Plan:
- Reset, then write 0x01..0x10 on 16 consecutive cycles -> count=16, full=1 after the 16th edge; a 17th write sets overflow=1 and count stays 16.
- Read 16 words from full -> rd_data=0x01..0x10 in order, each one cycle after rd_en with rd_valid=1; afterwards empty=1, count=0. An extra read sets underflow=1, rd_valid=0, rd_data holds 0x10.
- Full FIFO, wr_en=rd_en=1 with wr_data=0xAA -> rd_data=0x01 next cycle, count stays 16, overflow stays 0. After 16 further reads, the last word is 0xAA.
- Run 40 writes/reads with occupancy 3..7 to cross the pointer wrap twice -> data order preserved, full never asserts, count exact every cycle.
- af_level=12, ae_level=2: fill from 0 -> almost_empty=1 for count 0..2; almost_full rises at count=12, falls at 11. overflow=1 then err_clr=1 -> overflow=0. err_clr coincident with a new overflow -> overflow stays 1.
- Load 5 words, then flush=1 with wr_en=rd_en=1 -> count=0, empty=1, rd_valid=0 next cycle, no write taken. Assert rst mid-burst -> all outputs at reset values before the next clk edge.
